mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit AXI-lite-style main-memory port between the L1 instruction cache (read-only, requester 0) and the L1 data cache (read and write, requester 1).
- Grants one transaction at a time, round-robin between requesters, and holds the grant until that transaction completes.
- Steers address, data and handshakes between the granted cache and memory.
- A watchdog aborts a transaction that stalls too long and reports an error.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, cache line / memory data width
TIMEOUT, 1024, max cycles a granted transaction may wait for memory before abort (>=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ic_read_addr  in  ADDR_W  icache line read address (bits[3:0] ignored, forced 0 to memory)
ic_read_addr_valid  in  1  icache read request
ic_read_addr_ready  out  1  icache request accepted
ic_read_data  out  LINE_W  line returned to icache
ic_read_data_valid  out  1  icache read data strobe (1 cycle)
dc_read_addr  in  ADDR_W  dcache allocate address
dc_read_addr_valid  in  1  dcache read request
dc_read_addr_ready  out  1  dcache read accepted
dc_read_data  out  LINE_W  line returned to dcache
dc_read_data_valid  out  1  dcache read data strobe
dc_write_addr  in  ADDR_W  dcache writeback address
dc_write_addr_valid  in  1  dcache writeback request
dc_write_addr_ready  out  1  writeback accepted by memory
dc_write_data  in  LINE_W  writeback line
dc_strobe  in  LINE_W/8  writeback byte enables
mem_read_addr  out  ADDR_W  memory read address
mem_read_addr_valid  out  1  memory read request
mem_read_data  in  LINE_W  memory read data
mem_read_data_valid  in  1  memory read data strobe
mem_write_addr  out  ADDR_W  memory write address
mem_write_addr_valid  out  1  memory write request
mem_write_addr_ready  in  1  memory write accept (also completion; no write response channel)
mem_write_data  out  LINE_W  memory write data
mem_strobe  out  LINE_W/8  memory byte enables
err_timeout  out  1  sticky: a transaction was aborted by the watchdog

Behaviour:
- Reset (async assert, sync deassert handled by the top-level synchronizer):
  - state IDLE; rr_last=1, so the icache wins the first tie.
  - All valid/ready outputs 0; data/address outputs 0; err_timeout 0; watchdog counter 0.
- FSM states: IDLE, RD_IC, RD_DC, WR_DC.
- IDLE:
  - Requests: ic = ic_read_addr_valid; dc = dc_write_addr_valid | dc_read_addr_valid.
  - Only one requester active -> that requester wins. Both active -> the requester != rr_last wins.
  - Within dcache, write has priority over read; writeback must precede allocate.
  - Grant registered: transition takes effect next cycle; the request address is captured into addr_r.
  - No memory signal is driven in IDLE.
- RD_IC / RD_DC:
  - mem_read_addr_valid=1, mem_read_addr={addr_r[ADDR_W-1:4],4'b0}.
  - On mem_read_data_valid:
    - Pulse the granted cache's *_read_addr_ready and *_read_data_valid for exactly 1 cycle, same cycle, combinational pass-through of mem_read_data.
    - mem_read_addr_valid drops the same cycle.
    - rr_last <= granted id; -> IDLE.
  - The other cache's data_valid stays 0.
- WR_DC:
  - mem_write_addr_valid=1, write data/strobe passed through from dcache.
  - On mem_write_addr_ready: dc_write_addr_ready=1 for 1 cycle; rr_last<=1; -> IDLE.
- Requesters must hold valid and address stable until their ready; a valid dropped while granted is a protocol error (not checked).
- Watchdog:
  - Counter clears on entering any grant state, increments each cycle in it.
  - Reaching TIMEOUT-1 without completion -> err_timeout<=1 (sticky until reset), deassert memory valids, -> IDLE.
  - No ready/data_valid is returned to the requester; the cache stays stalled, by design, for debug.
- Minimum turnaround: one IDLE cycle between consecutive grants; back-to-back memory requests never overlap.
- Memory data returned in the same cycle as the request asserts is legal; it completes that cycle.
- Async reset mid-transaction: memory valids drop immediately; memory must tolerate an abandoned request.

Decomposition:
- Shared package gets:
  - arb_state_e (IDLE, RD_IC, RD_DC, WR_DC)
  - requester id constants REQ_IC=0, REQ_DC=1
  - LINE_W / line offset constants, shared with the caches
- One sub-module: rr_arb2, the 2-way round-robin picker. Inputs: req[1:0], last. Output: grant id. Combinational with no state; rr_last lives in mem_arbiter.

Test Plan:
- Single icache read 0x0000_1234, memory returns data 3 cycles later -> mem_read_addr=0x0000_1230; ic_read_data_valid one cycle with the data; dc outputs quiet.
- ic and dc reads requested in the same cycle after reset -> icache served first, then dcache; repeat both -> dcache served first (alternation).
- dc write 0x8000_0040 and read 0x8000_1040 both valid -> write issued first with strobe 0xFFFF passed through, then read; order never reversed.
- Memory never responds with TIMEOUT=16 -> after 15 grant cycles mem_read_addr_valid drops and err_timeout=1; stays set until rst_ni low.
- rst_ni asserted mid-RD_DC -> all outputs 0 asynchronously; after release the next request grants normally.
- Constant requests from both caches for 1000 transactions -> grants alternate strictly; no cycle with both mem valids high.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Line geometry here is also used by the L1 caches.
package mem_arbiter_pkg;

  localparam int LINE_W     = 128;
  localparam int LINE_BYTES = LINE_W / 8;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_IC,
    RD_DC,
    WR_DC
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter.
// master is the arbiter view, slave the caches/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic [ADDR_W-1:0]   ic_read_addr;
  logic                ic_read_addr_valid;
  logic                ic_read_addr_ready;
  logic [LINE_W-1:0]   ic_read_data;
  logic                ic_read_data_valid;

  logic [ADDR_W-1:0]   dc_read_addr;
  logic                dc_read_addr_valid;
  logic                dc_read_addr_ready;
  logic [LINE_W-1:0]   dc_read_data;
  logic                dc_read_data_valid;

  logic [ADDR_W-1:0]   dc_write_addr;
  logic                dc_write_addr_valid;
  logic                dc_write_addr_ready;
  logic [LINE_W-1:0]   dc_write_data;
  logic [LINE_W/8-1:0] dc_strobe;

  logic [ADDR_W-1:0]   mem_read_addr;
  logic                mem_read_addr_valid;
  logic [LINE_W-1:0]   mem_read_data;
  logic                mem_read_data_valid;

  logic [ADDR_W-1:0]   mem_write_addr;
  logic                mem_write_addr_valid;
  logic                mem_write_addr_ready;
  logic [LINE_W-1:0]   mem_write_data;
  logic [LINE_W/8-1:0] mem_strobe;

  logic                err_timeout;

  modport master (
    input  ic_read_addr, ic_read_addr_valid,
    output ic_read_addr_ready, ic_read_data, ic_read_data_valid,
    input  dc_read_addr, dc_read_addr_valid,
    output dc_read_addr_ready, dc_read_data, dc_read_data_valid,
    input  dc_write_addr, dc_write_addr_valid,
    output dc_write_addr_ready,
    input  dc_write_data, dc_strobe,
    output mem_read_addr, mem_read_addr_valid,
    input  mem_read_data, mem_read_data_valid,
    output mem_write_addr, mem_write_addr_valid,
    input  mem_write_addr_ready,
    output mem_write_data, mem_strobe,
    output err_timeout
  );

  modport slave (
    output ic_read_addr, ic_read_addr_valid,
    input  ic_read_addr_ready, ic_read_data, ic_read_data_valid,
    output dc_read_addr, dc_read_addr_valid,
    input  dc_read_addr_ready, dc_read_data, dc_read_data_valid,
    output dc_write_addr, dc_write_addr_valid,
    input  dc_write_addr_ready,
    output dc_write_data, dc_strobe,
    input  mem_read_addr, mem_read_addr_valid,
    output mem_read_data, mem_read_data_valid,
    input  mem_write_addr, mem_write_addr_valid,
    output mem_write_addr_ready,
    input  mem_write_data, mem_strobe,
    input  err_timeout
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; stateless, the
// last-served id is held by the caller.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = REQ_IC;
    unique case (req_i)
      2'b11:   grant_o = ~last_i;
      2'b10:   grant_o = REQ_DC;
      default: grant_o = REQ_IC;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between icache and dcache,
// one transaction at a time, with a stall watchdog.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.master bus
);
  import mem_arbiter_pkg::*;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_e        state_q;
  logic              rr_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;

  logic [1:0] req;
  logic       gnt;
  logic       in_ic;
  logic       in_dc;
  logic       in_wr;
  logic       in_rd;
  logic       rd_done;
  logic       wr_done;
  logic       expire;

  assign req = {bus.dc_write_addr_valid | bus.dc_read_addr_valid,
                bus.ic_read_addr_valid};

  rr_arb2 u_rr (
    .req_i   (req),
    .last_i  (rr_last_q),
    .grant_o (gnt)
  );

  assign in_ic   = (state_q == RD_IC);
  assign in_dc   = (state_q == RD_DC);
  assign in_wr   = (state_q == WR_DC);
  assign in_rd   = in_ic | in_dc;
  assign rd_done = in_rd & bus.mem_read_data_valid;
  assign wr_done = in_wr & bus.mem_write_addr_ready;
  assign expire  = (cnt_q == CW'(TIMEOUT - 2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= REQ_DC;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (|req) begin
            if (gnt == REQ_IC) begin
              state_q <= RD_IC;
              addr_q  <= bus.ic_read_addr;
            end else if (bus.dc_write_addr_valid) begin
              state_q <= WR_DC;
              addr_q  <= bus.dc_write_addr;
            end else begin
              state_q <= RD_DC;
              addr_q  <= bus.dc_read_addr;
            end
          end
        end
        default: begin
          if (rd_done | wr_done) begin
            rr_last_q <= in_ic ? REQ_IC : REQ_DC;
            state_q   <= IDLE;
          end else if (expire) begin
            // requester gets no response and stays stalled
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.mem_read_addr_valid  = in_rd;
  assign bus.mem_read_addr        = in_rd ?
    {addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : '0;
  assign bus.mem_write_addr_valid = in_wr;
  assign bus.mem_write_addr       = in_wr ? addr_q : '0;
  assign bus.mem_write_data       = in_wr ? bus.dc_write_data : '0;
  assign bus.mem_strobe           = in_wr ? bus.dc_strobe : '0;

  assign bus.ic_read_addr_ready  = in_ic & bus.mem_read_data_valid;
  assign bus.ic_read_data_valid  = in_ic & bus.mem_read_data_valid;
  assign bus.ic_read_data        = in_ic ? bus.mem_read_data : '0;
  assign bus.dc_read_addr_ready  = in_dc & bus.mem_read_data_valid;
  assign bus.dc_read_data_valid  = in_dc & bus.mem_read_data_valid;
  assign bus.dc_read_data        = in_dc ? bus.mem_read_data : '0;
  assign bus.dc_write_addr_ready = wr_done;

  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a
// transaction-level model of grants and completions.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int SW = LW / 8;
  localparam int TO = 16;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  mem_arbiter #(
    .ADDR_W  (AW),
    .LINE_W  (LW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // cache and memory stimulus state
  bit            ic_pend, dcr_pend, dcw_pend;
  logic [AW-1:0] ic_a, dcr_a, dcw_a;
  logic [LW-1:0] dcw_d;
  logic [SW-1:0] dcw_s;
  int            mem_mode;
  int            mem_lat;
  int            rd_wait, wr_wait;
  int            req_mode;
  logic [LW-1:0] cur_rdata;

  // model: 0 = icache read, 1 = dcache read, 2 = dcache write
  bit            m_busy, m_last, m_err;
  int            m_own, m_cyc;
  logic [AW-1:0] m_addr;

  int            log_q[$];
  int            ob_rv, ob_ic_dv, ob_dc_dv;
  bit            ob_rfirst;
  logic [AW-1:0] ob_raddr, ob_waddr;
  logic [SW-1:0] ob_strb;
  logic [LW-1:0] ob_icd, ob_memd;

  task automatic chkw(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    ob_rv = 0; ob_ic_dv = 0; ob_dc_dv = 0; ob_rfirst = 0;
    ob_raddr = '0; ob_waddr = '0; ob_strb = '0;
    ob_icd = '0; ob_memd = '0;
    log_q.delete();
  endtask

  task automatic clear_all();
    ic_pend = 0; dcr_pend = 0; dcw_pend = 0;
    rd_wait = 0; wr_wait = 0; req_mode = 0;
    m_busy = 0; m_last = 1; m_err = 0; m_own = 0; m_cyc = 0;
    bus.ic_read_addr_valid   = 0;
    bus.dc_read_addr_valid   = 0;
    bus.dc_write_addr_valid  = 0;
    bus.ic_read_addr         = '0;
    bus.dc_read_addr         = '0;
    bus.dc_write_addr        = '0;
    bus.dc_write_data        = '0;
    bus.dc_strobe            = '0;
    bus.mem_read_data        = '0;
    bus.mem_read_data_valid  = 0;
    bus.mem_write_addr_ready = 0;
  endtask

  task automatic chk_quiet(string tag);
    chkb({tag, "_mem_rv"}, bus.mem_read_addr_valid, 1'b0);
    chkb({tag, "_mem_wv"}, bus.mem_write_addr_valid, 1'b0);
    chkw({tag, "_mem_raddr"}, LW'(bus.mem_read_addr), '0);
    chkw({tag, "_mem_waddr"}, LW'(bus.mem_write_addr), '0);
    chkw({tag, "_mem_wdata"}, bus.mem_write_data, '0);
    chkw({tag, "_mem_strb"}, LW'(bus.mem_strobe), '0);
    chkb({tag, "_ic_rdy"}, bus.ic_read_addr_ready, 1'b0);
    chkb({tag, "_ic_dv"}, bus.ic_read_data_valid, 1'b0);
    chkb({tag, "_dc_rdy"}, bus.dc_read_addr_ready, 1'b0);
    chkb({tag, "_dc_dv"}, bus.dc_read_data_valid, 1'b0);
    chkb({tag, "_dcw_rdy"}, bus.dc_write_addr_ready, 1'b0);
    chkw({tag, "_ic_data"}, bus.ic_read_data, '0);
    chkw({tag, "_dc_data"}, bus.dc_read_data, '0);
    chkb({tag, "_err"}, bus.err_timeout, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 0;
    clear_all();
    @(negedge clk_i);
    #1;
    chk_quiet("rst");
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic compare_step();
    bit erv, ewv, rdone, wdone, ic_r, dc_r;
    erv   = m_busy && (m_own != 2);
    ewv   = m_busy && (m_own == 2);
    rdone = erv && bus.mem_read_data_valid;
    wdone = ewv && bus.mem_write_addr_ready;

    chkb("mem_rv", bus.mem_read_addr_valid, erv);
    chkb("mem_wv", bus.mem_write_addr_valid, ewv);
    if (erv) chkw("mem_raddr", LW'(bus.mem_read_addr), LW'(m_addr & ~32'hF));
    if (ewv) begin
      chkw("mem_waddr", LW'(bus.mem_write_addr), LW'(m_addr));
      chkw("mem_wdata", bus.mem_write_data, dcw_d);
      chkw("mem_strb", LW'(bus.mem_strobe), LW'(dcw_s));
    end
    chkb("ic_rdy", bus.ic_read_addr_ready, rdone && m_own == 0);
    chkb("ic_dv", bus.ic_read_data_valid, rdone && m_own == 0);
    chkb("dc_rdy", bus.dc_read_addr_ready, rdone && m_own == 1);
    chkb("dc_dv", bus.dc_read_data_valid, rdone && m_own == 1);
    chkb("dcw_rdy", bus.dc_write_addr_ready, wdone);
    if (rdone && m_own == 0) chkw("ic_data", bus.ic_read_data, cur_rdata);
    if (rdone && m_own == 1) chkw("dc_data", bus.dc_read_data, cur_rdata);
    chkb("err", bus.err_timeout, m_err);

    if (bus.mem_read_addr_valid) begin
      ob_rv++;
      if (!ob_rfirst) begin ob_rfirst = 1; ob_raddr = bus.mem_read_addr; end
    end
    if (bus.mem_write_addr_valid) begin
      ob_waddr = bus.mem_write_addr;
      ob_strb  = bus.mem_strobe;
    end
    if (bus.ic_read_data_valid) begin
      ob_ic_dv++; ob_icd = bus.ic_read_data; ob_memd = cur_rdata;
    end
    if (bus.dc_read_data_valid) ob_dc_dv++;

    // advance the model one clock
    ic_r = ic_pend;
    dc_r = dcr_pend || dcw_pend;
    if (m_busy) begin
      if (rdone || wdone) begin
        m_busy = 0;
        m_last = (m_own != 0);
      end else if (m_cyc >= TO - 1) begin
        m_busy = 0;
        m_err  = 1;
      end else begin
        m_cyc++;
      end
    end else if (ic_r || dc_r) begin
      m_busy = 1;
      m_cyc  = 1;
      if (ic_r && (!dc_r || m_last)) begin m_own = 0; m_addr = ic_a; end
      else if (dcw_pend) begin m_own = 2; m_addr = dcw_a; end
      else begin m_own = 1; m_addr = dcr_a; end
    end

    if (bus.ic_read_addr_ready) begin ic_pend = 0; log_q.push_back(0); end
    if (bus.dc_read_addr_ready) begin dcr_pend = 0; log_q.push_back(1); end
    if (bus.dc_write_addr_ready) begin dcw_pend = 0; log_q.push_back(2); end

    rd_wait = (bus.mem_read_addr_valid && !bus.mem_read_data_valid) ? rd_wait + 1 : 0;
    wr_wait = (bus.mem_write_addr_valid && !bus.mem_write_addr_ready) ? wr_wait + 1 : 0;
  endtask

  task automatic cycle();
    bit rr, wr;
    @(negedge clk_i);
    if (req_mode == 1) begin
      if (!ic_pend && $urandom_range(0, 2) == 0) begin ic_pend = 1; ic_a = $urandom; end
      if (!dcr_pend && $urandom_range(0, 3) == 0) begin dcr_pend = 1; dcr_a = $urandom; end
      if (!dcw_pend && $urandom_range(0, 3) == 0) begin
        dcw_pend = 1;
        dcw_a = $urandom & 32'hFFFF_FFF0;
        dcw_d = {$urandom, $urandom, $urandom, $urandom};
        dcw_s = SW'($urandom);
      end
    end else if (req_mode == 2) begin
      if (!ic_pend) begin ic_pend = 1; ic_a = $urandom; end
      if (!dcr_pend) begin dcr_pend = 1; dcr_a = $urandom; end
    end
    bus.ic_read_addr_valid  = ic_pend;
    bus.ic_read_addr        = ic_a;
    bus.dc_read_addr_valid  = dcr_pend;
    bus.dc_read_addr        = dcr_a;
    bus.dc_write_addr_valid = dcw_pend;
    bus.dc_write_addr       = dcw_a;
    bus.dc_write_data       = dcw_d;
    bus.dc_strobe           = dcw_s;
    rr = 0; wr = 0;
    case (mem_mode)
      0: begin rr = rd_wait >= mem_lat; wr = wr_wait >= mem_lat; end
      1: begin rr = $urandom_range(0, 1) == 1; wr = $urandom_range(0, 1) == 1; end
      default: begin rr = 0; wr = 0; end
    endcase
    cur_rdata = {$urandom, $urandom, $urandom, $urandom};
    bus.mem_read_data        = cur_rdata;
    bus.mem_read_data_valid  = rr && bus.mem_read_addr_valid;
    bus.mem_write_addr_ready = wr && bus.mem_write_addr_valid;
    #1;
    compare_step();
  endtask

  task automatic run_until(int n, int budget, string nm);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      errors++;
      $display("FAIL %s: completions %0d expected %0d", nm, log_q.size(), n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: run did not end");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int viol;
    ic_a = '0; dcr_a = '0; dcw_a = '0; dcw_d = '0; dcw_s = '0;
    mem_mode = 0; mem_lat = 0; cur_rdata = '0;
    clear_all();
    clear_obs();
    do_reset();

    // single icache read, data three cycles after the request
    clear_obs();
    mem_mode = 0; mem_lat = 3;
    ic_pend = 1; ic_a = 32'h0000_1234;
    run_until(1, 50, "t1_done");
    repeat (2) cycle();
    chkw("t1_raddr", LW'(ob_raddr), LW'(32'h0000_1230));
    chkw("t1_rv_cycles", LW'(ob_rv), LW'(4));
    chkw("t1_ic_dv", LW'(ob_ic_dv), LW'(1));
    chkw("t1_ic_data", ob_icd, ob_memd);
    chkw("t1_dc_dv", LW'(ob_dc_dv), LW'(0));
    chkw("t1_who", LW'(log_q[0]), LW'(0));

    // tie after reset: icache first
    do_reset();
    clear_obs();
    mem_mode = 0; mem_lat = 1;
    ic_pend = 1; ic_a = 32'h0000_2000;
    dcr_pend = 1; dcr_a = 32'h0000_3010;
    run_until(2, 60, "t2a_done");
    chkw("t2a_first", LW'(log_q[0]), LW'(0));
    chkw("t2a_second", LW'(log_q[1]), LW'(1));
    // icache served last, so the next tie goes to dcache
    clear_obs();
    ic_pend = 1; ic_a = 32'h0000_2040;
    run_until(1, 30, "t2b_ic");
    ic_pend = 1; ic_a = 32'h0000_2080;
    dcr_pend = 1; dcr_a = 32'h0000_3050;
    run_until(3, 60, "t2b_done");
    chkw("t2b_tie_first", LW'(log_q[1]), LW'(1));
    chkw("t2b_tie_second", LW'(log_q[2]), LW'(0));

    // writeback before allocate
    do_reset();
    clear_obs();
    mem_mode = 0; mem_lat = 2;
    dcw_pend = 1; dcw_a = 32'h8000_0040;
    dcw_d = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
    dcw_s = 16'hFFFF;
    dcr_pend = 1; dcr_a = 32'h8000_1040;
    run_until(2, 60, "t3_done");
    chkw("t3_first", LW'(log_q[0]), LW'(2));
    chkw("t3_second", LW'(log_q[1]), LW'(1));
    chkw("t3_waddr", LW'(ob_waddr), LW'(32'h8000_0040));
    chkw("t3_strb", LW'(ob_strb), LW'(16'hFFFF));
    chkw("t3_raddr", LW'(ob_raddr), LW'(32'h8000_1040));

    // silent memory trips the watchdog
    do_reset();
    clear_obs();
    mem_mode = 2;
    ic_pend = 1; ic_a = 32'h0000_5550;
    repeat (17) cycle();
    chkw("t4_rv_cycles", LW'(ob_rv), LW'(TO - 1));
    chkb("t4_err", bus.err_timeout, 1'b1);
    chkw("t4_no_dv", LW'(ob_ic_dv), LW'(0));
    repeat (20) cycle();
    chkb("t4_err_sticky", bus.err_timeout, 1'b1);
    do_reset();

    // async reset in the middle of a dcache read
    clear_obs();
    mem_mode = 2;
    dcr_pend = 1; dcr_a = 32'h4000_0088;
    repeat (3) cycle();
    chkb("t5_pre_rv", bus.mem_read_addr_valid, 1'b1);
    #2;
    rst_ni = 0;
    #1;
    chk_quiet("t5_async");
    clear_all();
    @(negedge clk_i);
    rst_ni = 1;
    clear_obs();
    mem_mode = 0; mem_lat = 1;
    dcr_pend = 1; dcr_a = 32'h4000_00C0;
    run_until(1, 20, "t5_after");
    chkw("t5_who", LW'(log_q[0]), LW'(1));
    chkw("t5_raddr", LW'(ob_raddr), LW'(32'h4000_00C0));

    // random traffic
    do_reset();
    clear_obs();
    mem_mode = 1; req_mode = 1;
    repeat (2000) cycle();

    // constant requests must alternate strictly
    do_reset();
    clear_obs();
    mem_mode = 1; req_mode = 2;
    run_until(1000, 20000, "alt_done");
    viol = 0;
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i] == log_q[i-1]) viol++;
    chkw("alt_viol", LW'(viol), LW'(0));
    chkw("alt_first", LW'(log_q.size() > 0 ? log_q[0] : -1), LW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
